// File: rtl/button_conditioner.sv
// Push-button front end: per-channel synchroniser, debouncer, press/release one-shots
// and a hold-to-repeat "fire" stream. The release one-shot is carried on port `rel`.
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] b,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rel,
  output logic [N_BTN-1:0] fire
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = $clog2(RC_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0]  DELAY_RELOAD  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0]  PERIOD_RELOAD = RC_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rep_state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic [RC_W-1:0]        rc;
    rep_state_t             state;
    logic                   level_q, press_q, rel_q, fire_q;
    logic                   s, flip, rise, fall;

    assign s    = sync_q[SYNC_STAGES-1];
    // The debounced level is about to change on this edge.
    assign flip = (s != level_q) && (cnt == CNT_LAST);
    assign rise = flip & s;
    assign fall = flip & ~s;

    // NOTE: non-blocking assignments make every stage sample the previous stage's old value,
    // so the chain really is SYNC_STAGES flops deep.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], b[i]};
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt     <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= rise;
        rel_q   <= fall;
        if (s == level_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level_q <= s;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    // fire is judged against the edge's rise/fall so it lines up with press and never
    // coincides with the release pulse.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= IDLE;
        rc     <= '0;
        fire_q <= 1'b0;
      end else begin
        fire_q <= 1'b0;
        case (state)
          IDLE: begin
            if (rise) begin
              fire_q <= 1'b1;
              state  <= HOLD;
              rc     <= DELAY_RELOAD;
            end
          end
          HOLD: begin
            if (fall || !level_q) begin
              state <= IDLE;
            end else if (!repeat_en[i]) begin
              rc <= DELAY_RELOAD;
            end else if (rc == '0) begin
              fire_q <= 1'b1;
              state  <= REPEAT;
              rc     <= PERIOD_RELOAD;
            end else begin
              rc <= rc - RC_W'(1);
            end
          end
          REPEAT: begin
            if (fall || !level_q) begin
              state <= IDLE;
            end else if (!repeat_en[i]) begin
              state <= HOLD;
              rc    <= DELAY_RELOAD;
            end else if (rc == '0) begin
              fire_q <= 1'b1;
              rc     <= PERIOD_RELOAD;
            end else begin
              rc <= rc - RC_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign level[i] = level_q;
    assign press[i] = press_q;
    assign rel[i]   = rel_q;
    assign fire[i]  = fire_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed vector table, hand-written
// repeat/reset sequences, then random button traffic against a reference model.
module tb_button_conditioner;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RP = 3;
  localparam int HW = SS + DC;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] b, repeat_en;
  logic [N-1:0] level, press, rel, fire;

  int total = 0;
  int bad   = 0;

  button_conditioner #(
    .N_BTN(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .b(b), .repeat_en(repeat_en),
    .level(level), .press(press), .rel(rel), .fire(fire)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: level flips once the synced value has disagreed with it for
  // DEBOUNCE_CYCLES edges in a row; repeats come from the count of enabled edges held.
  logic [HW-1:0] m_hist [N];
  logic [N-1:0]  m_level, m_press, m_rel, m_fire;
  int            m_age [N];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_hist[i] <= '0;
        m_age[i]  <= 0;
      end
      m_level <= '0;
      m_press <= '0;
      m_rel   <= '0;
      m_fire  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        logic [HW-1:0] h;
        logic          all_differ, r, f, fi;
        int            a;
        h = {m_hist[i][HW-2:0], b[i]};
        all_differ = 1'b1;
        for (int k = SS; k < SS + DC; k++)
          if (h[k] == m_level[i]) all_differ = 1'b0;
        r  = all_differ && !m_level[i];
        f  = all_differ &&  m_level[i];
        a  = m_age[i];
        fi = 1'b0;
        if (r) begin
          fi = 1'b1;
          a  = 0;
        end else if (!f && m_level[i]) begin
          if (repeat_en[i]) begin
            a  = a + 1;
            fi = (a == RD) || (a > RD && (a - RD) % RP == 0);
          end else begin
            a = 0;
          end
        end
        m_hist[i]  <= h;
        m_age[i]   <= a;
        m_press[i] <= r;
        m_rel[i]   <= f;
        m_fire[i]  <= fi;
        if (all_differ) m_level[i] <= ~m_level[i];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic rep_fire(input int d);
    return (d == RD) || (d > RD && (d - RD) % RP == 0);
  endfunction

  // Counts edges until press[ch]; gives up (returning 20) after 20 edges.
  task automatic wait_press(input int ch, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!press[ch] && n < 20);
  endtask

  typedef struct {
    logic [3:0] b;
    logic [3:0] en;
    int         cyc;
    logic [3:0] lv, pr, rl, fi;
  } vec_t;

  vec_t vt[$];

  initial begin
    int n;
    int bt_run [N];
    logic [N-1:0] outs_exp;

    reset = 1'b0;
    b = '0;
    repeat_en = '0;
    step(2);
    check("reset_outputs", {level, press, rel, fire}, 16'h0);
    reset = 1'b1;

    // Single press with no repeat, then a short glitch and a bounce on channel 1.
    vt.push_back(vec_t'{4'h0, 4'h0,  3, 4'h0, 4'h0, 4'h0, 4'h0});
    vt.push_back(vec_t'{4'h1, 4'h0,  5, 4'h0, 4'h0, 4'h0, 4'h0});
    vt.push_back(vec_t'{4'h1, 4'h0,  1, 4'h1, 4'h1, 4'h0, 4'h1});
    vt.push_back(vec_t'{4'h1, 4'h0,  1, 4'h1, 4'h0, 4'h0, 4'h0});
    vt.push_back(vec_t'{4'h1, 4'h0, 13, 4'h1, 4'h0, 4'h0, 4'h0});
    vt.push_back(vec_t'{4'h0, 4'h0,  5, 4'h1, 4'h0, 4'h0, 4'h0});
    vt.push_back(vec_t'{4'h0, 4'h0,  1, 4'h0, 4'h0, 4'h1, 4'h0});
    vt.push_back(vec_t'{4'h0, 4'h0,  1, 4'h0, 4'h0, 4'h0, 4'h0});
    vt.push_back(vec_t'{4'h2, 4'h0,  3, 4'h0, 4'h0, 4'h0, 4'h0});
    vt.push_back(vec_t'{4'h0, 4'h0,  8, 4'h0, 4'h0, 4'h0, 4'h0});
    vt.push_back(vec_t'{4'h2, 4'h0,  1, 4'h0, 4'h0, 4'h0, 4'h0});
    vt.push_back(vec_t'{4'h0, 4'h0,  1, 4'h0, 4'h0, 4'h0, 4'h0});
    vt.push_back(vec_t'{4'h2, 4'h0,  5, 4'h0, 4'h0, 4'h0, 4'h0});
    vt.push_back(vec_t'{4'h2, 4'h0,  1, 4'h2, 4'h2, 4'h0, 4'h2});
    vt.push_back(vec_t'{4'h2, 4'h0,  1, 4'h2, 4'h0, 4'h0, 4'h0});
    vt.push_back(vec_t'{4'h0, 4'h0,  8, 4'h0, 4'h0, 4'h0, 4'h0});

    for (int v = 0; v < vt.size(); v++) begin
      b = vt[v].b;
      repeat_en = vt[v].en;
      step(vt[v].cyc);
      check($sformatf("vec%0d", v), {level, press, rel, fire},
            {vt[v].lv, vt[v].pr, vt[v].rl, vt[v].fi});
    end

    // Channels 0 and 3 rise together while channel 1 toggles every cycle.
    for (int k = 1; k <= 7; k++) begin
      b = {1'b1, 1'b0, k[0], 1'b1};
      step(1);
      if (k < 6)       outs_exp = 4'h0;
      else             outs_exp = 4'h9;
      check($sformatf("t5_level_e%0d", k), level, outs_exp);
      check($sformatf("t5_press_e%0d", k), press, (k == 6) ? 4'h9 : 4'h0);
    end
    b = '0;
    step(10);

    // Hold-to-repeat; release timed to land on a would-be repeat slot.
    repeat_en = 4'b0100;
    b = 4'b0100;
    wait_press(2, n);
    check("t3_press_latency", n, SS + DC);
    check("t3_fire_at_press", fire[2], 1'b1);
    for (int d = 1; d <= 23; d++) begin
      step(1);
      check($sformatf("t3_fire_p%0d", d), fire[2], rep_fire(d));
    end
    b = '0;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!rel[2] && n < 20);
    check("t3_rel_latency", n, SS + DC);
    check("t3_fire_at_rel", fire[2], 1'b0);
    step(1);
    check("t3_idle_after", {level, press, rel, fire}, 16'h0);
    step(5);

    // Repeat enable dropped mid-stream: full delay restarts when re-enabled.
    b = 4'b0100;
    wait_press(2, n);
    check("t4_press_latency", n, SS + DC);
    for (int d = 1; d <= 30; d++) begin
      step(1);
      check($sformatf("t4_fire_p%0d", d), fire[2],
            (d == 8) || (d == 11) || (d >= 23 && (d - 23) % 3 == 0));
      if (d == 12) repeat_en[2] = 1'b0;
      if (d == 15) repeat_en[2] = 1'b1;
    end
    b = '0;
    step(10);

    // Asynchronous reset while repeating, button still held.
    b = 4'b0100;
    wait_press(2, n);
    step(10);
    check("t6_level_before", level[2], 1'b1);
    #2 reset = 1'b0;
    #1 check("t6_async_clear", {level, press, rel, fire}, 16'h0);
    step(2);
    check("t6_held_clear", {level, press, rel, fire}, 16'h0);
    reset = 1'b1;
    wait_press(2, n);
    check("t6_press_after_reset", n, SS + DC);
    b = '0;
    step(10);

    // Random bouncing and long holds on all channels against the model.
    for (int i = 0; i < N; i++) bt_run[i] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step(1);
      check($sformatf("model_c%0d", cyc), {level, press, rel, fire},
            {m_level, m_press, m_rel, m_fire});
      for (int i = 0; i < N; i++) begin
        if (bt_run[i] == 0) begin
          b[i] = ~b[i];
          bt_run[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
        end else begin
          bt_run[i]--;
        end
        if ($urandom_range(0, 49) == 0) repeat_en[i] = ~repeat_en[i];
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
